huffman_decoder: RTL and testbench

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

---
 rtl/huffman_decoder.sv | 125 ++++++++++++
 tb/tb_huffman_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for a fixed 18-symbol prefix-free code, walking the code tree one bit per clock.
// A symbol completes on the edge that consumes its last bit, and flag/sx are registered on that edge.
module huffman_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in,
    output logic [4:0] sx,
    output logic       flag
);

    typedef enum logic [4:0] {
        ROOT,
        P0,
        P1,
        P11,
        P111,
        P1110,
        P1111,
        P11100,
        P11101,
        P111011,
        P11110,
        P11111,
        P111100,
        P111101,
        P111110,
        P111111,
        P1111111
    } state_t;

    state_t     state_q, state_d;
    logic       flag_q, flag_d;
    logic [4:0] sx_q, sx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ROOT;
            flag_q  <= 1'b0;
            sx_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            sx_q    <= sx_d;
        end
    end

    // A leaf sends the walk back to ROOT and loads the symbol in the same cycle.
    always_comb begin
        state_d = ROOT;
        flag_d  = 1'b0;
        sx_d    = sx_q;
        unique case (state_q)
            ROOT:    state_d = in ? P1 : P0;
            P0: begin
                flag_d = 1'b1;
                sx_d   = in ? 5'd2 : 5'd1;
            end
            P1: begin
                if (in) state_d = P11;
                else begin
                    flag_d = 1'b1;
                    sx_d   = 5'd3;
                end
            end
            P11: begin
                if (in) state_d = P111;
                else begin
                    flag_d = 1'b1;
                    sx_d   = 5'd4;
                end
            end
            P111:    state_d = in ? P1111 : P1110;
            P1110:   state_d = in ? P11101 : P11100;
            P11100: begin
                flag_d = 1'b1;
                sx_d   = in ? 5'd6 : 5'd5;
            end
            P11101: begin
                if (in) state_d = P111011;
                else begin
                    flag_d = 1'b1;
                    sx_d   = 5'd7;
                end
            end
            P111011: begin
                flag_d = 1'b1;
                sx_d   = in ? 5'd9 : 5'd8;
            end
            P1111:   state_d = in ? P11111 : P11110;
            P11110:  state_d = in ? P111101 : P111100;
            P111100: begin
                flag_d = 1'b1;
                sx_d   = in ? 5'd11 : 5'd10;
            end
            P111101: begin
                flag_d = 1'b1;
                sx_d   = in ? 5'd13 : 5'd12;
            end
            P11111:  state_d = in ? P111111 : P111110;
            P111110: begin
                flag_d = 1'b1;
                sx_d   = in ? 5'd15 : 5'd14;
            end
            P111111: begin
                if (in) state_d = P1111111;
                else begin
                    flag_d = 1'b1;
                    sx_d   = 5'd16;
                end
            end
            P1111111: begin
                flag_d = 1'b1;
                sx_d   = in ? 5'd18 : 5'd17;
            end
            default: begin
                state_d = ROOT;
                flag_d  = 1'b0;
            end
        endcase
    end

    assign flag = flag_q;
    assign sx   = sx_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: a table-lookup reference model pushes the expected
// flag/sx for every driven bit into a scoreboard queue, popped after each rising edge.
module tb_huffman_decoder;

    typedef struct packed {
        logic       flag;
        logic [4:0] sx;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in;
    logic [4:0] sx;
    logic       flag;

    int checks = 0;
    int passes = 0;

    exp_t expQ[$];
    exp_t exp;

    int         codeLen[18] = '{2, 2, 2, 3, 6, 6, 6, 7, 7, 7, 7, 7, 7, 7, 7, 7, 8, 8};
    logic [7:0] codeVal[18] = '{8'h00, 8'h01, 8'h02, 8'h06, 8'h38, 8'h39, 8'h3A, 8'h76, 8'h77,
                                8'h78, 8'h79, 8'h7A, 8'h7B, 8'h7C, 8'h7D, 8'h7E, 8'hFE, 8'hFF};

    logic [7:0] accBits;
    int         accLen;
    logic [4:0] lastSx;

    huffman_decoder dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .sx   (sx),
        .flag (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accumulate bits and look the prefix up in the code table.
    task automatic modelStep(input logic b);
        logic [7:0] mask;
        logic       hit;
        hit     = 1'b0;
        accBits = {accBits[6:0], b};
        accLen++;
        mask    = 8'hFF >> (8 - accLen);
        for (int i = 0; i < 18; i++) begin
            if (!hit && accLen == codeLen[i] && (accBits & mask) == codeVal[i]) begin
                hit    = 1'b1;
                lastSx = 5'(i + 1);
            end
        end
        if (hit) begin
            accBits = 8'h00;
            accLen  = 0;
        end
        expQ.push_back('{flag: hit, sx: lastSx});
    endtask

    task automatic modelReset();
        accBits = 8'h00;
        accLen  = 0;
        lastSx  = 5'd0;
    endtask

    // Drive one bit on the falling edge and sample #1 after the following rising edge.
    task automatic applyStimulus(input logic b);
        @(negedge clk);
        reset = 1'b0;
        in    = b;
        modelStep(b);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset = 1'b1;
        in    = 1'($urandom);
        modelReset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        doReset();
        checks++;
        if (flag !== 1'b0) $display("[TB] FAIL reset_flag: got %0b expected 0", flag);
        else passes++;
        checks++;
        if (sx !== 5'd0) $display("[TB] FAIL reset_sx: got %0d expected 0", sx);
        else passes++;
    endtask

    task automatic test_symbol1();
        logic bits[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(bits[k]);
            exp = expQ.pop_front();
            checks++;
            if (flag !== exp.flag || sx !== exp.sx)
                $display("[TB] FAIL symbol1 bit %0d: got flag=%0b sx=%0d expected flag=%0b sx=%0d",
                         k, flag, sx, exp.flag, exp.sx);
            else passes++;
        end
        checks++;
        if (flag !== 1'b1 || sx !== 5'd3)
            $display("[TB] FAIL symbol1_final: got flag=%0b sx=%0d expected flag=1 sx=3", flag, sx);
        else passes++;
    endtask

    task automatic test_symbol4();
        logic bits[3] = '{1'b1, 1'b1, 1'b0};
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(bits[k]);
            exp = expQ.pop_front();
            checks++;
            if (flag !== exp.flag || sx !== exp.sx)
                $display("[TB] FAIL symbol4 bit %0d: got flag=%0b sx=%0d expected flag=%0b sx=%0d",
                         k, flag, sx, exp.flag, exp.sx);
            else passes++;
        end
        checks++;
        if (flag !== 1'b1 || sx !== 5'd4)
            $display("[TB] FAIL symbol4_final: got flag=%0b sx=%0d expected flag=1 sx=4", flag, sx);
        else passes++;
    endtask

    task automatic test_longest();
        doReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1);
            exp = expQ.pop_front();
            checks++;
            if (flag !== exp.flag || sx !== exp.sx)
                $display("[TB] FAIL longest bit %0d: got flag=%0b sx=%0d expected flag=%0b sx=%0d",
                         k, flag, sx, exp.flag, exp.sx);
            else passes++;
        end
        checks++;
        if (flag !== 1'b1 || sx !== 5'd18)
            $display("[TB] FAIL longest_final: got flag=%0b sx=%0d expected flag=1 sx=18", flag, sx);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic bits[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                           1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        doReset();
        for (int k = 0; k < 13; k++) begin
            applyStimulus(bits[k]);
            exp = expQ.pop_front();
            checks++;
            if (flag !== exp.flag || sx !== exp.sx)
                $display("[TB] FAIL back_to_back bit %0d: got flag=%0b sx=%0d expected flag=%0b sx=%0d",
                         k, flag, sx, exp.flag, exp.sx);
            else passes++;
            if (k == 6) begin
                checks++;
                if (flag !== 1'b1 || sx !== 5'd8)
                    $display("[TB] FAIL back_to_back_sym8: got flag=%0b sx=%0d expected flag=1 sx=8", flag, sx);
                else passes++;
            end
        end
        checks++;
        if (flag !== 1'b1 || sx !== 5'd6)
            $display("[TB] FAIL back_to_back_sym6: got flag=%0b sx=%0d expected flag=1 sx=6", flag, sx);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic bits[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        doReset();
        for (int k = 0; k < 5; k++) begin
            if (k == 3) begin
                doReset();
                checks++;
                if (flag !== 1'b0 || sx !== 5'd0)
                    $display("[TB] FAIL reset_mid_clear: got flag=%0b sx=%0d expected flag=0 sx=0", flag, sx);
                else passes++;
            end
            applyStimulus(bits[k]);
            exp = expQ.pop_front();
            checks++;
            if (flag !== exp.flag || sx !== exp.sx)
                $display("[TB] FAIL reset_mid bit %0d: got flag=%0b sx=%0d expected flag=%0b sx=%0d",
                         k, flag, sx, exp.flag, exp.sx);
            else passes++;
        end
        checks++;
        if (flag !== 1'b1 || sx !== 5'd2)
            $display("[TB] FAIL reset_mid_final: got flag=%0b sx=%0d expected flag=1 sx=2", flag, sx);
        else passes++;
    endtask

    task automatic test_all_codes();
        doReset();
        for (int i = 0; i < 18; i++) begin
            for (int j = codeLen[i] - 1; j >= 0; j--) begin
                applyStimulus(codeVal[i][j]);
                exp = expQ.pop_front();
                checks++;
                if (flag !== exp.flag || sx !== exp.sx)
                    $display("[TB] FAIL all_codes sym %0d bit %0d: got flag=%0b sx=%0d expected flag=%0b sx=%0d",
                             i + 1, j, flag, sx, exp.flag, exp.sx);
                else passes++;
            end
            checks++;
            if (flag !== 1'b1 || sx !== 5'(i + 1))
                $display("[TB] FAIL all_codes_sym %0d: got flag=%0b sx=%0d", i + 1, flag, sx);
            else passes++;
        end
    endtask

    task automatic test_random();
        int sinceFlag;
        doReset();
        sinceFlag = 0;
        for (int k = 0; k < 600; k++) begin
            applyStimulus(1'($urandom));
            exp = expQ.pop_front();
            checks++;
            if (flag !== exp.flag || sx !== exp.sx)
                $display("[TB] FAIL random bit %0d: got flag=%0b sx=%0d expected flag=%0b sx=%0d",
                         k, flag, sx, exp.flag, exp.sx);
            else passes++;
            sinceFlag = flag ? 0 : sinceFlag + 1;
            if (sinceFlag >= 8) begin
                checks++;
                $display("[TB] FAIL random_gap: %0d edges without flag, limit 7", sinceFlag);
                sinceFlag = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        in    = 1'b0;
        modelReset();
        test_reset();
        test_symbol1();
        test_symbol4();
        test_longest();
        test_back_to_back();
        test_reset_mid();
        test_all_codes();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
